// File: rtl/edsac_sram_pkg.sv
// Shared constants and types for the EDSAC external SRAM arbiter.
package edsac_sram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic PORT_STORE  = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/edsac_sram_arb_pick.sv
// Combinational winner select for the two SRAM requesters.
// EDSAC_SRAM_ARB_RR_EN selects round robin; otherwise port 0 has fixed priority.
module edsac_sram_arb_pick
  import edsac_sram_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_vld,
  output logic gnt_port
);

  assign gnt_vld = req0 | req1;

`ifdef EDSAC_SRAM_ARB_RR_EN
  // ptr holds the last served port, so a tie goes to the other one
  always_comb begin
    if (req0 && req1) gnt_port = ~ptr;
    else if (req0)    gnt_port = PORT_STORE;
    else              gnt_port = PORT_LOADER;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign gnt_port   = req0 ? PORT_STORE : PORT_LOADER;
`endif

endmodule

// File: rtl/edsac_sram_arbiter.sv
// Two-port arbiter and setup/strobe/hold sequencer for the external async SRAM.
// EDSAC_SRAM_ARB_RR_EN enables round-robin arbitration between the ports.
module edsac_sram_arbiter #(
  parameter int ADDR_W      = edsac_sram_pkg::ADDR_W,
  parameter int DATA_W      = edsac_sram_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_dat_o,
  input  logic [DATA_W-1:0] ram_dat_i,
  output logic              ram_dat_oe,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_cs_n
);
  import edsac_sram_pkg::*;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              ptr;
  logic              gnt_vld, gnt_port;
  logic              lat_we, lat_port;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              cur_we, cur_port;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cs_n_d, oe_n_d, we_n_d, dat_oe_d, ack0_d, ack1_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] dat_d;

`ifdef EDSAC_SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ptr <= PORT_STORE;
    else if (state == IDLE && gnt_vld) ptr <= gnt_port;
  end
`else
  assign ptr = PORT_STORE;
`endif

  edsac_sram_arb_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .ptr      (ptr),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // In IDLE the winner's inputs feed the pin registers so SETUP starts on the grant edge
  always_comb begin
    if (state == IDLE) begin
      cur_port  = gnt_port;
      cur_we    = gnt_port ? we1    : we0;
      cur_addr  = gnt_port ? addr1  : addr0;
      cur_wdata = gnt_port ? wdata1 : wdata0;
    end else begin
      cur_port  = lat_port;
      cur_we    = lat_we;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:    if (gnt_vld) state_d = SETUP;
      SETUP:   begin state_d = ACCESS; cnt_d = '0; end
      ACCESS:  if (cnt == LAST) state_d = DONE;
               else             cnt_d   = cnt + 4'd1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state and registered, so they never glitch
    cs_n_d   = (state_d == IDLE);
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dat_oe_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    adr_d    = ram_adr;
    dat_d    = ram_dat_o;
    if (state_d != IDLE) adr_d = cur_addr;
    case (state_d)
      SETUP: begin
        oe_n_d   = cur_we;
        dat_oe_d = cur_we;
        if (cur_we) dat_d = cur_wdata;
      end
      ACCESS: begin
        oe_n_d   = cur_we;
        we_n_d   = ~cur_we;
        dat_oe_d = cur_we;
      end
      DONE: begin
        dat_oe_d = cur_we;
        ack0_d   = (cur_port == PORT_STORE);
        ack1_d   = (cur_port == PORT_LOADER);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_port   <= PORT_STORE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ram_cs_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_dat_oe <= 1'b0;
      ram_adr    <= '0;
      ram_dat_o  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ram_cs_n   <= cs_n_d;
      ram_oe_n   <= oe_n_d;
      ram_we_n   <= we_n_d;
      ram_dat_oe <= dat_oe_d;
      ram_adr    <= adr_d;
      ram_dat_o  <= dat_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      busy       <= (state_d != IDLE);
      if (state == IDLE && gnt_vld) begin
        lat_we    <= cur_we;
        lat_port  <= cur_port;
        lat_addr  <= cur_addr;
        lat_wdata <= cur_wdata;
      end
      if (state == ACCESS && cnt == LAST && !lat_we) rdata <= ram_dat_i;
    end
  end

endmodule

// File: tb/tb_edsac_sram_arbiter.sv
// Self-checking bench for edsac_sram_arbiter: vector table plus ack-driven scoreboard.
module tb_edsac_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata, ram_dat_o, ram_dat_i;
  logic [AW-1:0] ram_adr;
  logic          ram_dat_oe, ram_oe_n, ram_we_n, ram_cs_n;

  edsac_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_adr(ram_adr), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
    .ram_dat_oe(ram_dat_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_cs_n(ram_cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small SRAM model, aliased on the low address byte
  logic [DW-1:0] mem [256];
  always @(posedge clk)
    if (!ram_cs_n && !ram_we_n) mem[ram_adr[7:0]] <= ram_dat_o;
  assign ram_dat_i = (!ram_cs_n && !ram_oe_n) ? mem[ram_adr[7:0]] : 16'h0000;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  // monitor: strobe lengths per transaction, checked against the scoreboard on each ack
  int cs_len, we_len, oe_len, doe_len;
  logic [DW-1:0] last_rd;
  exp_t m;
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_len = 0; we_len = 0; oe_len = 0; doe_len = 0; last_rd = '0;
      check("rst_ack", {ack0, ack1}, 0);
      check("rst_strobes", {ram_cs_n, ram_oe_n, ram_we_n, ram_dat_oe, busy}, 5'b11100);
    end else begin
      if (!ram_cs_n) cs_len++;
      if (!ram_we_n) we_len++;
      if (!ram_oe_n) oe_len++;
      if (ram_dat_oe) doe_len++;
      check("busy_vs_cs", busy, !ram_cs_n);
      check("one_ack", ack0 & ack1, 0);
      if (ack0 | ack1) begin
        if (sb.size() == 0) check("unexpected_ack", {ack0, ack1}, 0);
        else begin
          m = sb.pop_front();
          check("ack_port", ack1, m.port);
          check("ack_adr", ram_adr, m.addr);
          check("cs_len", cs_len, WC + 2);
          check("we_len", we_len, m.we ? WC : 0);
          check("oe_len", oe_len, m.we ? 0 : WC + 1);
          check("doe_len", doe_len, m.we ? WC + 2 : 0);
          if (m.we) begin
            check("dat_o", ram_dat_o, m.wdata);
            check("rdata_hold", rdata, last_rd);
          end else begin
            check("rdata", rdata, m.rdata);
            last_rd = m.rdata;
          end
        end
        cs_len = 0; we_len = 0; oe_len = 0; doe_len = 0;
      end
    end
  end

  // holds req until ack (bounded), drops it in the ack cycle
  task automatic drive(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int st_cyc, output int ack_cyc);
    bit done;
    done = 0;
    ack_cyc = -1;
    @(negedge clk);
    st_cyc = cyc;
    if (port == 1'b0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else              begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if ((port == 1'b0 && ack0) || (port == 1'b1 && ack1)) begin
        done = 1;
        ack_cyc = cyc;
      end
    end
    if (port == 1'b0) req0 = 0; else req1 = 0;
    check("ack_seen", done, 1);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int s, a, s0, a0, s1, a1, b1, b2;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs[0] = '{1'b0, 1'b1, 19'h00123, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 19'h00123, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 19'h00045, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 19'h00045, 16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 19'h00000, 16'hA5A5, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 19'h00001, 16'h5A5A, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 19'h00000, 16'h0000, 16'hA5A5};
    vecs[7] = '{1'b0, 1'b0, 19'h00001, 16'h0000, 16'h5A5A};
    vecs[8] = '{1'b1, 1'b1, 19'h7FFFF, 16'h0001, 16'h0000};
    vecs[9] = '{1'b1, 1'b0, 19'h7FFFF, 16'h0000, 16'h0001};

    // reset held 3 cycles, then idle with no request
    repeat (3) @(negedge clk);
    check("rst_adr", ram_adr, 0);
    check("rst_dat_o", ram_dat_o, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_cs_n", ram_cs_n, 1);
    end

    // table: each vector starts from IDLE, ack lands WC+2 cycles after the sampling edge
    foreach (vecs[i]) begin
      @(negedge clk);
      push(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
      drive(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, s, a);
      check("latency", a - s, WC + 2);
    end

    // contention: last grant went to port 1, both request together, each re-requests on ack
    repeat (2) @(negedge clk);
`ifdef EDSAC_SRAM_ARB_RR_EN
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(1, 0, 19'h1, 16'h0, 16'h5A5A);
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(1, 0, 19'h1, 16'h0, 16'h5A5A);
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
`else
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(1, 0, 19'h1, 16'h0, 16'h5A5A);
    push(1, 0, 19'h1, 16'h0, 16'h5A5A);
`endif
    fork
      begin
        repeat (3) drive(0, 0, 19'h0, 16'h0, s0, a0);
      end
      begin
        repeat (2) drive(1, 0, 19'h1, 16'h0, s1, a1);
      end
    join

    // back-to-back port 0 reads, second presented in the first ack cycle
    repeat (2) @(negedge clk);
    push(0, 0, 19'h0, 16'h0, 16'hA5A5);
    push(0, 0, 19'h1, 16'h0, 16'h5A5A);
    drive(0, 0, 19'h0, 16'h0, s, b1);
    drive(0, 0, 19'h1, 16'h0, s, b2);
    check("b2b_period", b2 - b1, WC + 3);

    // reset mid-ACCESS of a write: strobes drop at once, request is serviced afterwards
    repeat (2) @(negedge clk);
    push(0, 1, 19'h2, 16'h1111, 16'h0);
    fork
      drive(0, 1, 19'h2, 16'h1111, s, a);
      begin
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_we_n", ram_we_n, 0);
        rst_n = 0;
        #1;
        check("async_we_n", ram_we_n, 1);
        check("async_cs_n", ram_cs_n, 1);
        check("async_dat_oe", ram_dat_oe, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
      end
    join
    @(negedge clk);
    push(1, 0, 19'h2, 16'h0, 16'h1111);
    drive(1, 0, 19'h2, 16'h0, s, a);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edsac_sram_arbiter.md
Name: edsac_sram_arbiter

Overview:
- Owns the board's external asynchronous SRAM (ADR/DAT/RAMOE/RAMWE/RAMCS) and shares it between two requesters.
  - Port 0: the EDSAC main store (mercury-delay-line emulation).
  - Port 1: the initial-orders loader / monitor.
- Sequences each access through a fixed setup/strobe/hold timing at the 100 MHz board clock. Requesters use the same clock, qualified by their own enables.
- Sits at chip level, between the edsac core and the SRAM pins.

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, strobe length in clk cycles. Legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  100 MHz board clock.
- rst_n  in  1  asynchronous reset, active low.
- req0 / req1  in  1  access request, ports 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, shared by both ports; valid in the ack cycle, held until the next read completes.
- busy  out  1  high in every state except IDLE.
- ram_adr  out  ADDR_W  to ADR.
- ram_dat_o  out  DATA_W  write data to DAT.
- ram_dat_i  in  DATA_W  read data from DAT.
- ram_dat_oe  out  1  DAT output enable (pad tristate).
- ram_oe_n / ram_we_n / ram_cs_n  out  1  active-low SRAM strobes.

Behaviour:
- Reset values: ram_cs_n = ram_oe_n = ram_we_n = 1; ram_adr = 0; ram_dat_o = 0; ram_dat_oe = 0; ack0 = ack1 = 0; rdata = 0; busy = 0; state IDLE; RR pointer = 0.
- Assertion of rst_n forces all strobes high immediately, without waiting for clk. A write interrupted mid-strobe may leave the target word corrupt; this is accepted.
- Handshake:
  - Requester holds req, we, addr and wdata stable from assertion until it sees ack.
  - In the ack cycle a registered requester either drops req or presents a new transaction.
  - IDLE samples req in the cycle after ack, so no request is ever serviced twice.
- FSM:
  - IDLE: if any req, choose a winner, latch its addr/wdata/we into internal registers, go to SETUP.
  - SETUP (1 cycle): cs_n = 0; ram_adr = latched addr. Read: oe_n = 0. Write: dat_oe = 1, ram_dat_o = latched data. we_n = 1.
  - ACCESS (WAIT_CYCLES cycles): cs_n = 0. Read: oe_n = 0; rdata captured from ram_dat_i at the final ACCESS edge. Write: we_n = 0, dat_oe = 1.
  - DONE (1 cycle): cs_n = 0, oe_n = 1, we_n = 1. dat_oe stays 1 for writes (data hold). Winner's ack = 1. Next state IDLE.
- Latency: ack is in cycle WAIT_CYCLES+2 after the IDLE cycle that saw req. Back-to-back transaction period is WAIT_CYCLES+3 cycles.
- Address and data stay stable from SETUP through DONE; no strobe glitches between states, as all strobes are registered.
- Arbitration is fixed priority: port 0 wins whenever both req are high in IDLE. A request arriving while busy waits; it is never dropped.
- Exactly one of ack0/ack1 can be high in any cycle.

Optional Feature:
- Macro: EDSAC_SRAM_ARB_RR_EN.
- Defined: two-way round robin.
  - The pointer records the last granted port.
  - When both ports request, the port not last served wins.
  - A single requester is always granted.
- Undefined: fixed priority to port 0, and no pointer register exists.

Decomposition:
- Shared package edsac_sram_pkg holds:
  - ADDR_W and DATA_W constants.
  - State encoding: IDLE = 0, SETUP = 1, ACCESS = 2, DONE = 3.
  - Port index constants: PORT_STORE = 0, PORT_LOADER = 1.
- One natural sub-module: edsac_sram_arb_pick, a combinational winner select. It takes req0, req1 and the pointer, and contains the RR_EN conditional.
- The FSM and pin drive stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles -> all strobes 1, dat_oe 0, ack 0, busy 0. Deassert rst_n -> state stays IDLE with no req.
- Port 0 write, WAIT_CYCLES = 2: addr 19'h00123, wdata 16'hBEEF -> cs_n low 4 cycles, we_n low exactly 2 cycles, dat_oe high 4 cycles, ack0 in cycle 4.
- Port 1 read of 19'h00123 against an SRAM model -> oe_n low 3 cycles, rdata = 16'hBEEF in the ack1 cycle.
- Both ports request in the same IDLE cycle; port 0 re-requests on every ack:
  - Without the macro -> port 0 is served continuously and ack1 never occurs.
  - With EDSAC_SRAM_ARB_RR_EN -> grants alternate 0, 1, 0, 1.
- Back-to-back port 0 reads of addr 0 then addr 1 -> the two ack0 pulses are exactly 5 cycles apart.
- rst_n pulled low mid-ACCESS of a write -> we_n and cs_n go high asynchronously, no ack is issued, and the pending req is serviced after reset.
